// File: rtl/shift_pkg.sv
// Shared types and sizing helpers for the parallel-in, serial-out transmitter.
package shift_pkg;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } shift_state_t;

   function automatic int cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/shift_par_out.sv
// Parallel-in, serial-out transmitter: MSB-first on ser_out, one bit per serclk,
// with a one-word holding buffer so consecutive words leave without idle bits.
module shift_par_out
   import shift_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             serclk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             ser_out,
   output logic             ser_gate,
   output logic             word_end,
   output logic             busy
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   shift_state_t     state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             hold_full_q, hold_full_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             accept;
   logic             load;
   logic             last_bit;

   assign din_ready = !hold_full_q && !reset;
   assign accept    = din_valid && din_ready;
   assign last_bit  = (state_q == S_SHIFT) && (cnt_q == LAST_CNT);

   // The shifter reloads when idle or on the last bit, if anything is available.
   assign load = ((state_q == S_IDLE) || last_bit) && (hold_full_q || accept);

   always_comb begin
      state_d     = state_q;
      sreg_d      = sreg_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      cnt_d       = cnt_q;

      if (load) begin
         sreg_d  = hold_full_q ? hold_q : din;
         cnt_d   = '0;
         state_d = S_SHIFT;
      end else if (state_q == S_SHIFT) begin
         if (last_bit) begin
            state_d = S_IDLE;
         end else begin
            sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
            cnt_d  = cnt_q + CNT_W'(1);
         end
      end

      if (load && hold_full_q) begin
         hold_full_d = 1'b0;
      end

      // An accepted word that did not bypass into the shifter waits in hold.
      if (accept && !(load && !hold_full_q)) begin
         hold_d      = din;
         hold_full_d = 1'b1;
      end
   end

   always_ff @(posedge serclk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         sreg_q      <= '0;
         hold_full_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         sreg_q      <= sreg_d;
         hold_full_q <= hold_full_d;
         cnt_q       <= cnt_d;
      end
   end

   // Hold contents are only meaningful while hold_full_q is set.
   always_ff @(posedge serclk) begin
      hold_q <= hold_d;
   end

   assign ser_out  = (state_q == S_SHIFT) ? sreg_q[WIDTH-1] : 1'b0;
   assign ser_gate = (state_q == S_SHIFT);
   assign word_end = last_bit;
   assign busy     = (state_q == S_SHIFT) || hold_full_q;

endmodule

// File: tb/tb_shift_par_out.sv
// Directed bench for shift_par_out with WIDTH = 8 and a falling-edge loopback receiver.
module tb_shift_par_out;

   logic       serclk;
   logic       reset;
   logic [7:0] din;
   logic       din_valid;
   logic       din_ready;
   logic       ser_out;
   logic       ser_gate;
   logic       word_end;
   logic       busy;
   logic [7:0] rx;

   int tests;
   int fails;

   typedef struct {
      logic [7:0] word;
      logic [7:0] bits;
      logic       loop;
   } vec_t;

   vec_t vecs[4];

   shift_par_out #(.WIDTH(8)) dut (
      .serclk    (serclk),
      .reset     (reset),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .ser_out   (ser_out),
      .ser_gate  (ser_gate),
      .word_end  (word_end),
      .busy      (busy)
   );

   initial serclk = 1'b0;
   always #5 serclk = ~serclk;

   // Downstream serial-in register sampling on the falling edge.
   always @(negedge serclk) rx <= {rx[6:0], ser_out};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick_sample();
      @(negedge serclk);
      #1;
   endtask

   task automatic send_word(input vec_t v);
      tick_sample();
      din       = v.word;
      din_valid = 1'b1;
      #1;
      check("ready_before_send", 32'(din_ready), 32'd1);
      @(posedge serclk);
      #1;
      din_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick_sample();
         check("single_ser_out", 32'(ser_out), 32'(v.bits[7-i]));
         check("single_gate", 32'(ser_gate), 32'd1);
         check("single_word_end", 32'(word_end), 32'(i == 7));
         if (v.loop && i == 7) check("loopback_rx", 32'(rx), 32'(v.word));
      end
      tick_sample();
      check("after_gate", 32'(ser_gate), 32'd0);
      check("after_ser_out", 32'(ser_out), 32'd0);
      check("after_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      logic [15:0] exp16;
      logic [23:0] exp24;
      logic [7:0]  words3 [3];
      logic        acc;
      int          nacc;

      tests     = 0;
      fails     = 0;
      din       = 8'h00;
      din_valid = 1'b0;
      reset     = 1'b1;

      vecs[0] = '{word: 8'hA5, bits: 8'b1010_0101, loop: 1'b0};
      vecs[1] = '{word: 8'h00, bits: 8'b0000_0000, loop: 1'b0};
      vecs[2] = '{word: 8'h5A, bits: 8'b0101_1010, loop: 1'b1};
      vecs[3] = '{word: 8'h81, bits: 8'b1000_0001, loop: 1'b1};

      repeat (2) @(posedge serclk);
      #1;
      check("rst_ser_out", 32'(ser_out), 32'd0);
      check("rst_gate", 32'(ser_gate), 32'd0);
      check("rst_word_end", 32'(word_end), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(din_ready), 32'd0);
      reset = 1'b0;
      #1;
      check("ready_after_rst", 32'(din_ready), 32'd1);

      for (int v = 0; v < 4; v++) send_word(vecs[v]);

      // Back-to-back: 0x3C then 0xC3 with no idle bit between them.
      exp16 = 16'b0011_1100_1100_0011;
      tick_sample();
      din       = 8'h3C;
      din_valid = 1'b1;
      for (int c = 0; c <= 16; c++) begin
         @(posedge serclk);
         #1;
         if (c == 0) din = 8'hC3;
         if (c == 1) din_valid = 1'b0;
         tick_sample();
         if (c < 16) begin
            check("b2b_ser_out", 32'(ser_out), 32'(exp16[15-c]));
            check("b2b_gate", 32'(ser_gate), 32'd1);
            check("b2b_word_end", 32'(word_end), 32'(c == 7 || c == 15));
         end else begin
            check("b2b_gate_end", 32'(ser_gate), 32'd0);
         end
      end

      // Backpressure: three words offered with din_valid held high.
      words3[0] = 8'h11;
      words3[1] = 8'h22;
      words3[2] = 8'h33;
      exp24     = 24'h112233;
      nacc      = 0;
      tick_sample();
      din       = words3[0];
      din_valid = 1'b1;
      #1;
      acc = din_valid && din_ready;
      for (int c = 0; c <= 24; c++) begin
         @(posedge serclk);
         #1;
         if (acc) begin
            nacc++;
            if (nacc < 3) din = words3[nacc];
            else din_valid = 1'b0;
         end
         tick_sample();
         check("bp_ready", 32'(din_ready), 32'(c == 0 || c == 8 || c >= 16));
         if (c < 24) begin
            check("bp_ser_out", 32'(ser_out), 32'(exp24[23-c]));
            check("bp_gate", 32'(ser_gate), 32'd1);
            check("bp_word_end", 32'(word_end), 32'(c == 7 || c == 15 || c == 23));
         end else begin
            check("bp_gate_end", 32'(ser_gate), 32'd0);
         end
         acc = din_valid && din_ready;
      end
      check("bp_accepts", 32'(nacc), 32'd3);

      // Reset in the middle of 0xF0, then a clean 0xFF.
      tick_sample();
      din       = 8'hF0;
      din_valid = 1'b1;
      @(posedge serclk);
      #1;
      din_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick_sample();
         check("rstmid_bits", 32'(ser_out), 32'(i < 4));
      end
      check("rstmid_busy_before", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      check("rstmid_ser_out", 32'(ser_out), 32'd0);
      check("rstmid_gate", 32'(ser_gate), 32'd0);
      check("rstmid_word_end", 32'(word_end), 32'd0);
      check("rstmid_busy", 32'(busy), 32'd0);
      check("rstmid_ready", 32'(din_ready), 32'd0);
      @(posedge serclk);
      #1;
      reset = 1'b0;
      send_word('{word: 8'hFF, bits: 8'b1111_1111, loop: 1'b1});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/shift_par_out.md
# shift_par_out

Parallel-in, serial-out transmitter that sits directly upstream of the serial-in shift register.
- Accepts WIDTH-bit words over a valid/ready handshake and drives them MSB-first on `ser_out`, one bit per `serclk` cycle.
- Updates on the rising edge of `serclk`, so the downstream register, which samples on the falling edge, gets a half-cycle of setup.
- A one-word holding buffer allows back-to-back words with no idle bit between them.

## Interface
- `WIDTH`, default 8: word width in bits; legal range WIDTH >= 2.
- `serclk`  in  1  serial bit clock; every flop in this block is clocked on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `din`  in  WIDTH  parallel word to transmit.
- `din_valid`  in  1  `din` is valid this cycle.
- `din_ready`  out  1  block can accept a word; combinational, `!hold_full && !reset`.
- `ser_out`  out  1  serial data, MSB first; 0 when no word is being sent.
- `ser_gate`  out  1  high for every cycle in which `ser_out` carries a word bit.
- `word_end`  out  1  high during the last (LSB) bit of each word.
- `busy`  out  1  `state == S_SHIFT || hold_full`.

## Operation
- **Storage:** shifter `sreg[WIDTH-1:0]`; holding register `hold` with flag `hold_full`; bit counter `cnt` of width `CNT_W`.
- **Handshake:** a transfer occurs on a rising edge when `din_valid && din_ready`. `din` must stay stable while `din_valid` is high and the word has not been accepted.
- **Load source:** whenever the shifter loads, it takes `hold` if `hold_full`, otherwise the word accepted on that edge (bypass). An accepted word that is not bypassed goes into `hold`.
- **FSM states:** `S_IDLE`, `S_SHIFT`.
- **S_IDLE**
  - Accepted word → load shifter, `cnt=0`, go to `S_SHIFT`.
  - Otherwise stay in `S_IDLE`.
- **S_SHIFT, `cnt < WIDTH-1`:** shift left one bit, `cnt++`.
- **S_SHIFT, `cnt == WIDTH-1`**
  - If `hold_full` or a word is accepted this edge → load shifter, `cnt=0`, stay in `S_SHIFT`.
  - Otherwise → go to `S_IDLE`.
- **Outputs**
  - `ser_out = sreg[WIDTH-1]` in `S_SHIFT`, else 0.
  - `ser_gate = (state == S_SHIFT)`.
  - `word_end = (state == S_SHIFT && cnt == WIDTH-1)`.
- **Simultaneous events:** on a last-bit edge with `hold_full` and a new accept (impossible, since `din_ready` is low when `hold_full`) nothing special is needed. With `hold` empty and a new accept on the last-bit edge, the word bypasses straight into the shifter.
- **Reset values:**
  - `state=S_IDLE`, `cnt=0`, `sreg=0`, `hold_full=0`.
  - `ser_out=0`, `ser_gate=0`, `word_end=0`, `busy=0`, `din_ready=0` while `reset` is high.
- **Reset mid-word:** the partial word and any held word are discarded. Outputs go to their reset values immediately (asynchronously), with no completion of the remaining bits.

## Timing
- Accept at edge k while `S_IDLE`:
  - MSB is on `ser_out` from edge k to edge k+1.
  - Bit i (MSB = 0) is driven after edge k+i.
  - `word_end` is high between edges k+WIDTH-1 and k+WIDTH.
  - Back in `S_IDLE` after edge k+WIDTH if no further word is pending.
- Back-to-back words: the next word's MSB follows the previous LSB on the very next cycle. `ser_gate` stays high continuously.
- Sustained throughput: one word per WIDTH cycles. The holding register refills within the window in which the current word shifts.
- Downstream sampling: the downstream register samples bit i at the falling edge between edges k+i and k+i+1. The full word is present in that register at the falling edge inside the `word_end` cycle.

## Structure
- Package `shift_pkg` holds:
  - state enum `shift_state_t` {`S_IDLE`, `S_SHIFT`};
  - `localparam`/function `CNT_W = $clog2(WIDTH)`.
- No sub-module: the shifter, holding register and FSM are small enough to live in one module.

## Test plan
All scenarios use WIDTH = 8.
- **Single word:** offer 0xA5 when idle → `ser_out` reads 1,0,1,0,0,1,0,1 on 8 consecutive cycles; `word_end` is high only on the 8th; `ser_gate` is high for exactly 8 cycles; then idle with `ser_out=0`.
- **Back-to-back:** offer 0x3C then 0xC3 continuously → 16 contiguous `ser_gate` cycles carrying 00111100 11000011, with 2 `word_end` pulses at cycles 8 and 16.
- **Backpressure:** hold `din_valid` high with 0x11, 0x22, 0x33 → `din_ready` drops after the second accept and rises again at the first word's last-bit edge. All three words are sent in order with no gaps.
- **Reset mid-word:** assert `reset` after 3 bits of 0xF0 → all outputs go to 0 at once; after deassertion, 0xFF is sent cleanly as eight 1s.
- **Loopback:** feed `ser_out` into the downstream serial-in shift register (falling-edge sampling); send 0x5A → its parallel output equals 0x5A at the falling edge during `word_end`.
